// File: rtl/cordic_rot_iter_if.sv
// Handshake bundle for the iterative rotation-mode CORDIC.
// The master side supplies polar operands and consumes rectangular results.
interface cordic_rot_iter_if #(
  parameter int BITSIZE = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [BITSIZE-1:0] r_in;
  logic [BITSIZE-1:0] theta_in;
  logic               out_valid;
  logic               out_ready;
  logic [BITSIZE:0]   x_out;
  logic [BITSIZE:0]   y_out;

  modport master (
    output in_valid, r_in, theta_in, out_ready,
    input  in_ready, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, r_in, theta_in, out_ready,
    output in_ready, out_valid, x_out, y_out
  );
endinterface

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: (r, theta) -> (r*cos, r*sin).
// One micro-rotation per clock, a single operation in flight, valid/ready on both sides.
module cordic_rot_iter #(
  parameter int          BITSIZE = 16,
  parameter int          ITERS   = 16,
  parameter logic [15:0] KINV    = 16'h26DD
) (
  input  logic             clk,
  input  logic             rst_n,
  cordic_rot_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  localparam int XW = BITSIZE + 2;
  localparam logic [3:0] CNT_LAST = 4'(ITERS - 1);
  // +/- pi/2 in Q2.14
  localparam logic signed [BITSIZE-1:0] THETA_LIM = BITSIZE'(25736);
  localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** BITSIZE) - 1);
  localparam logic signed [XW-1:0] SAT_LO = -SAT_HI;

  // atan(2^-i) in Q2.14, entry 0 in the low 16 bits
  localparam logic [255:0] ATAN_PACKED = {
    16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
    16'h0080, 16'h0100, 16'h0200, 16'h03FF, 16'h07F5, 16'h0FAE, 16'h1DAC, 16'h3244
  };

  logic [15:0] atan_tab [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_atan
      assign atan_tab[gi] = ATAN_PACKED[gi*16 +: 16];
    end
  endgenerate

  state_t                    state_reg;
  logic [BITSIZE-1:0]        r_reg;
  logic signed [BITSIZE-1:0] theta_reg;
  logic signed [XW-1:0]      x_reg, y_reg;
  logic signed [BITSIZE-1:0] z_reg;
  logic [3:0]                cnt_reg;
  logic                      out_valid_reg;
  logic signed [BITSIZE:0]   x_out_reg, y_out_reg;

  logic signed [BITSIZE-1:0] theta_s, theta_clamped;
  logic [BITSIZE+15:0]       prod;
  logic signed [XW-1:0]      x_pre;
  logic signed [XW-1:0]      x_sh, y_sh, x_rot, y_rot;
  logic signed [BITSIZE-1:0] atan_i, z_rot;

  // Clip the incoming angle to +/- pi/2 so the rotation always converges
  assign theta_s = $signed(bus.theta_in);
  always_comb begin
    theta_clamped = theta_s;
    if (theta_s > THETA_LIM) begin
      theta_clamped = THETA_LIM;
    end else if (theta_s < -THETA_LIM) begin
      theta_clamped = -THETA_LIM;
    end
  end

  // Gain-compensated start vector: r * KINV in Q0.14, truncated
  assign prod  = (BITSIZE+16)'(r_reg) * (BITSIZE+16)'(KINV);
  assign x_pre = $signed(XW'(prod >> 14));

  // One micro-rotation, direction picked by the sign of the residual angle
  assign x_sh   = x_reg >>> cnt_reg;
  assign y_sh   = y_reg >>> cnt_reg;
  assign atan_i = $signed(BITSIZE'(atan_tab[cnt_reg]));
  always_comb begin
    if (!z_reg[BITSIZE-1]) begin
      x_rot = x_reg - y_sh;
      y_rot = y_reg + x_sh;
      z_rot = z_reg - atan_i;
    end else begin
      x_rot = x_reg + y_sh;
      y_rot = y_reg - x_sh;
      z_rot = z_reg + atan_i;
    end
  end

  function automatic logic signed [BITSIZE:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[BITSIZE:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[BITSIZE:0];
    end
    return v[BITSIZE:0];
  endfunction

  // Control FSM and datapath registers; outputs only move when a result is published
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      theta_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      x_out_reg     <= '0;
      y_out_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            r_reg     <= bus.r_in;
            theta_reg <= theta_clamped;
            state_reg <= PRE;
          end
        end
        PRE: begin
          x_reg     <= x_pre;
          y_reg     <= '0;
          z_reg     <= theta_reg;
          cnt_reg   <= '0;
          state_reg <= ITER;
        end
        ITER: begin
          x_reg   <= x_rot;
          y_reg   <= y_rot;
          z_reg   <= z_rot;
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_reg) begin
            x_out_reg     <= sat(x_reg);
            y_out_reg     <= sat(y_reg);
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.x_out     = x_out_reg;
  assign bus.y_out     = y_out_reg;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Bench for cordic_rot_iter: directed corner cases plus random operands, checked
// against an integer model of the rotation algorithm and a coarse band around r*cos/r*sin.
module tb_cordic_rot_iter;

  localparam int LAT      = 18;     // accept edge -> out_valid edge
  localparam int LIM      = 25736;  // pi/2 in Q2.14
  localparam int IDEAL_TOL = 16;    // coarse band vs. ideal trig (exactness comes from the model)

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   valid_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int atan_q14 [16] = '{'h3244, 'h1DAC, 'h0FAE, 'h07F5, 'h03FF, 'h0200, 'h0100, 'h0080,
                        'h0040, 'h0020, 'h0010, 'h0008, 'h0004, 'h0002, 'h0001, 'h0000};

  cordic_rot_iter_if #(.BITSIZE(16)) bus ();

  cordic_rot_iter #(.BITSIZE(16), .ITERS(16), .KINV(16'h26DD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_cmp++;
    if (got - exp > tol || exp - got > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  function automatic int clamp_theta(input int th);
    if (th > LIM) return LIM;
    if (th < -LIM) return -LIM;
    return th;
  endfunction

  function automatic int sat(input int v);
    if (v > 65535) return 65535;
    if (v < -65535) return -65535;
    return v;
  endfunction

  // Rotation-mode CORDIC on plain integers: prescale by KINV, then 16 shift-add steps
  function automatic void model(input int r, input int th, output int xo, output int yo);
    int x, y, z, nx, ny;
    x = int'((longint'(r) * 64'd9949) >>> 14);
    y = 0;
    z = clamp_theta(th);
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin
        nx = x - (y >>> i);
        ny = y + (x >>> i);
        z  = z - atan_q14[i];
      end else begin
        nx = x + (y >>> i);
        ny = y - (x >>> i);
        z  = z + atan_q14[i];
      end
      x = nx;
      y = ny;
    end
    xo = sat(x);
    yo = sat(y);
  endfunction

  function automatic int rnd(input real v);
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  // Present an operand and wait for the accepting edge
  task automatic start_op(input int r, input int th, input bit keep_valid);
    int n;
    bus.r_in     = 16'(r);
    bus.theta_in = 16'(th);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1, 0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
    check("in_ready_busy", int'(bus.in_ready), 0, 0);
  endtask

  // Wait for the result, compare it, report one line for the transaction
  task automatic finish_op(input int r, input int th, output int mx, output int my);
    int n, gx, gy, t;
    real ix, iy;
    model(r, th, mx, my);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 0, 1, 0);
    end else begin
      valid_cyc = cyc;
      gx = int'($signed(bus.x_out));
      gy = int'($signed(bus.y_out));
      t  = clamp_theta(th);
      ix = real'(r) * $cos(real'(t) / 16384.0);
      iy = real'(r) * $sin(real'(t) / 16384.0);
      check("latency", valid_cyc - acc_cyc, LAT, 0);
      check("x_model", gx, mx, 0);
      check("y_model", gy, my, 0);
      check("x_ideal", gx, sat(rnd(ix)), IDEAL_TOL);
      check("y_ideal", gy, sat(rnd(iy)), IDEAL_TOL);
      $display("op r=%0d theta=%0d -> x=%0d y=%0d (model %0d %0d, ideal %0d %0d) lat=%0d",
               r, th, gx, gy, mx, my, rnd(ix), rnd(iy), valid_cyc - acc_cyc);
    end
  endtask

  // Handshake edge with out_ready already high: valid drops, block returns to IDLE
  task automatic handshake();
    @(posedge clk); #1;
    check("hs_out_valid", int'(bus.out_valid), 0, 0);
    check("hs_in_ready", int'(bus.in_ready), 1, 0);
  endtask

  task automatic simple_op(input int r, input int th);
    int mx, my;
    start_op(r, th, 1'b0);
    finish_op(r, th, mx, my);
    handshake();
  endtask

  initial begin
    int mx, my, r, th, stall;
    int b2b_r [4]  = '{12345, 0, 40000, 500};
    int b2b_th [4] = '{3000, 5000, -20000, 25000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.r_in      = '0;
    bus.theta_in  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1, 0);
    check("rst_out_valid", int'(bus.out_valid), 0, 0);
    check("rst_x_out", int'($signed(bus.x_out)), 0, 0);
    check("rst_y_out", int'($signed(bus.y_out)), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic angles, including the clamp boundaries
    simple_op(10000, 0);
    simple_op(16384, 12868);
    simple_op(20000, -8579);
    simple_op(65535, 25736);
    simple_op(65535, 32767);
    simple_op(65535, -32768);
    simple_op(0, -12000);

    // Backpressure: result must hold, new requests must be ignored
    bus.out_ready = 1'b0;
    start_op(30000, 5000, 1'b0);
    finish_op(30000, 5000, mx, my);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.r_in     = 16'($urandom);
      bus.theta_in = 16'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", int'(bus.out_valid), 1, 0);
      check("bp_in_ready", int'(bus.in_ready), 0, 0);
      check("bp_x_hold", int'($signed(bus.x_out)), mx, 0);
      check("bp_y_hold", int'($signed(bus.y_out)), my, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    handshake();
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_idle_valid", int'(bus.out_valid), 0, 0);
      check("bp_idle_ready", int'(bus.in_ready), 1, 0);
      check("bp_x_keep", int'($signed(bus.x_out)), mx, 0);
    end

    // Asynchronous reset in the middle of the iterations (cnt = 7)
    start_op(20000, 10000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0, 0);
    check("mid_rst_x_out", int'($signed(bus.x_out)), 0, 0);
    check("mid_rst_y_out", int'($signed(bus.y_out)), 0, 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_no_output", int'(bus.out_valid), 0, 0);
    end
    simple_op(1000, 0);

    // Back-to-back with in_valid held high: next accept two edges after out_valid rises
    for (int i = 0; i < 4; i++) begin
      start_op(b2b_r[i], b2b_th[i], 1'b1);
      if (i > 0) check("b2b_reaccept_gap", acc_cyc - valid_cyc, 2, 0);
      finish_op(b2b_r[i], b2b_th[i], mx, my);
      handshake();
    end
    bus.in_valid = 1'b0;

    // Random operands over the full 16-bit angle range, random output stalls
    for (int i = 0; i < 24; i++) begin
      r     = int'($urandom_range(0, 65535));
      th    = int'($signed(16'($urandom)));
      stall = int'($urandom_range(0, 3));
      bus.out_ready = (stall == 0);
      start_op(r, th, 1'b0);
      finish_op(r, th, mx, my);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("rnd_stall_x", int'($signed(bus.x_out)), mx, 0);
        check("rnd_stall_valid", int'(bus.out_valid), 1, 0);
      end
      bus.out_ready = 1'b1;
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
